// File: rtl/key_cond_pkg.sv
// Shared constants and helpers for the pushbutton conditioning slice.
// Key levels are active-low: 0 means the button is held down.
package key_cond_pkg;

    localparam logic KEY_RELEASED = 1'b1;
    localparam logic KEY_PRESSED  = 1'b0;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

    // Counter must be able to hold DEBOUNCE_CYCLES itself; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter, stable level,
// registered press/release strobes and, with KEY_CONDITIONER_TOGGLE_EN, a toggle latch.
module debounce_channel
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic toggle_o
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // The edge that would bring the count to DEBOUNCE_CYCLES commits the new level instead.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        press_d   = (stable_prev_q == KEY_RELEASED) && (stable_q == KEY_PRESSED);
        release_d = (stable_prev_q == KEY_PRESSED)  && (stable_q == KEY_RELEASED);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            stable_q      <= KEY_RELEASED;
            stable_prev_q <= KEY_RELEASED;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            press_q       <= press_d;
            release_q     <= release_d;
        end
    end

`ifdef KEY_CONDITIONER_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            toggle_q <= 1'b0;
        end else if (press_d) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign toggle_o = toggle_q;
`else
    assign toggle_o = 1'b0;
`endif

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// DE2-115 pushbutton conditioner: NUM_KEYS independent debounce channels.
// Optional per-key toggle latches are built when KEY_CONDITIONER_TOGGLE_EN is defined.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY_IN,
    output logic [NUM_KEYS-1:0] KEY_OUT,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_TOGGLE
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i    (CLOCK_50),
            .rst_ni   (RESET_N),
            .key_i    (KEY_IN[k]),
            .level_o  (KEY_OUT[k]),
            .press_o  (KEY_PRESS[k]),
            .release_o(KEY_RELEASE[k]),
            .toggle_o (KEY_TOGGLE[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DEBOUNCE_CYCLES=4; honours KEY_CONDITIONER_TOGGLE_EN.
module tb_key_conditioner;
    import key_cond_pkg::*;

    localparam int unsigned NK = 4;
    localparam int unsigned D  = SIM_DEBOUNCE_CYCLES;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N  = 1'b0;
    logic [NK-1:0] KEY_IN   = '0;
    logic [NK-1:0] KEY_OUT;
    logic [NK-1:0] KEY_PRESS;
    logic [NK-1:0] KEY_RELEASE;
    logic [NK-1:0] KEY_TOGGLE;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .KEY_IN     (KEY_IN),
        .KEY_OUT    (KEY_OUT),
        .KEY_PRESS  (KEY_PRESS),
        .KEY_RELEASE(KEY_RELEASE),
        .KEY_TOGGLE (KEY_TOGGLE)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int            at;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] out;
        logic [NK-1:0] tog;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NK-1:0] out_m = '1;
    logic [NK-1:0] tog_m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe the DUT presents must match the oldest pending expectation.
    always @(negedge CLOCK_50) begin
        if ((KEY_PRESS | KEY_RELEASE) != '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got press=%b release=%b expected none (cycle %0d)",
                         KEY_PRESS, KEY_RELEASE, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_cycle", cyc, mon_e.at);
                check("press", {28'd0, KEY_PRESS}, {28'd0, mon_e.press});
                check("release", {28'd0, KEY_RELEASE}, {28'd0, mon_e.rel});
                check("level_at_strobe", {28'd0, KEY_OUT}, {28'd0, mon_e.out});
                check("toggle_at_strobe", {28'd0, KEY_TOGGLE}, {28'd0, mon_e.tog});
            end
        end
    end

    // Issue one accepted change (input change or reset release) and check level latency.
    task automatic apply(input string tag, input bit rst_rel, input logic [NK-1:0] kin,
                         input logic [NK-1:0] p, input logic [NK-1:0] r,
                         input logic [NK-1:0] newout);
        int   n;
        exp_t e;
        @(negedge CLOCK_50);
        if (rst_rel) RESET_N = 1'b1;
        else         KEY_IN  = kin;
        n = cyc;
`ifdef KEY_CONDITIONER_TOGGLE_EN
        tog_m = tog_m ^ p;
`endif
        e.at = n + int'(D) + 3; e.press = p; e.rel = r; e.out = newout; e.tog = tog_m;
        sb.push_back(e);
        repeat (int'(D) + 1) @(negedge CLOCK_50);
        check({tag, "_hold"}, {28'd0, KEY_OUT}, {28'd0, out_m});
        @(negedge CLOCK_50);
        check({tag, "_level"}, {28'd0, KEY_OUT}, {28'd0, newout});
        out_m = newout;
        repeat (3) @(negedge CLOCK_50);
    endtask

    initial begin
        // Reset with every key held down
        RESET_N = 1'b0;
        KEY_IN  = 4'b0000;
        repeat (3) @(negedge CLOCK_50);
        check("rst_out", {28'd0, KEY_OUT}, 32'hF);
        check("rst_press", {28'd0, KEY_PRESS}, 32'h0);
        check("rst_release", {28'd0, KEY_RELEASE}, 32'h0);
        check("rst_toggle", {28'd0, KEY_TOGGLE}, 32'h0);
        apply("held_thru_reset", 1'b1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);

        apply("release01", 1'b0, 4'b0011, 4'b0000, 4'b0011, 4'b0011);
        apply("press0", 1'b0, 4'b0010, 4'b0001, 4'b0000, 4'b0010);

        // Bounce on key 1: 2-cycle pulses never survive the filter
        for (int i = 0; i < 4; i++) begin
            @(negedge CLOCK_50);
            KEY_IN = (i % 2 == 0) ? 4'b0000 : 4'b0010;
            @(negedge CLOCK_50);
        end
        check("bounce_level", {28'd0, KEY_OUT}, 32'h2);
        apply("bounce_final", 1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        apply("simul_rel23", 1'b0, 4'b1100, 4'b0000, 4'b1100, 4'b1100);

        // Reset after 3 mismatch cycles on key 2
        @(negedge CLOCK_50);
        KEY_IN = 4'b1000;
        repeat (5) @(negedge CLOCK_50);
        check("midcount_level", {28'd0, KEY_OUT}, 32'hC);
        RESET_N = 1'b0;
        KEY_IN  = 4'b1111;
        #1;
        check("midrst_out", {28'd0, KEY_OUT}, 32'hF);
        check("midrst_press", {28'd0, KEY_PRESS}, 32'h0);
        check("midrst_release", {28'd0, KEY_RELEASE}, 32'h0);
        check("midrst_toggle", {28'd0, KEY_TOGGLE}, 32'h0);
        out_m = 4'b1111;
        tog_m = 4'b0000;
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        check("post_rst_level", {28'd0, KEY_OUT}, 32'hF);

        // Three press/release cycles on key 0
        for (int i = 0; i < 3; i++) begin
            apply("tog_press", 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b1110);
            apply("tog_release", 1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b1111);
        end
`ifdef KEY_CONDITIONER_TOGGLE_EN
        check("toggle_final", {28'd0, KEY_TOGGLE}, 32'h1);
`else
        check("toggle_final", {28'd0, KEY_TOGGLE}, 32'h0);
`endif

        repeat (10) @(negedge CLOCK_50);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
